priority_encoder_4to2: RTL and testbench



---
 rtl/priority_encoder_4to2.sv | 49 ++++
 tb/tb_priority_encoder_4to2.sv | 120 ++++++++++++
 2 files changed

// File: rtl/priority_encoder_4to2.sv
// priority_encoder_4to2: 4-input priority encoder (I3 highest) with valid flag
// and an optional output register stage selected by REG_OUT.
module priority_encoder_4to2 #(
    parameter bit REG_OUT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic I0,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    output logic Y1,
    output logic Y0,
    output logic valid
);

    logic [1:0] code_d;
    logic       valid_d;

    always_comb begin
        code_d  = I3 ? 2'b11 : I2 ? 2'b10 : I1 ? 2'b01 : 2'b00;
        valid_d = I0 | I1 | I2 | I3;
    end

    if (REG_OUT) begin : g_reg
        logic [1:0] code_q;
        logic       valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                code_q  <= 2'b00;
                valid_q <= 1'b0;
            end else begin
                code_q  <= code_d;
                valid_q <= valid_d;
            end
        end

        assign {Y1, Y0} = code_q;
        assign valid    = valid_q;
    end else begin : g_comb
        // Clock and reset are intentionally ignored in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};
        assign {Y1, Y0}       = code_d;
        assign valid          = valid_d;
    end

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// tb_priority_encoder_4to2: checks combinational and registered builds side by
// side; registered expectations flow through a scoreboard queue.
module tb_priority_encoder_4to2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in = 4'b0000;
    logic       c_y1, c_y0, c_valid;
    logic       r_y1, r_y0, r_valid;
    logic [2:0] sb[$];
    logic [2:0] last_reg = 3'b000;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    priority_encoder_4to2 #(.REG_OUT(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n),
        .I0(in[0]), .I1(in[1]), .I2(in[2]), .I3(in[3]),
        .Y1(c_y1), .Y0(c_y0), .valid(c_valid)
    );

    priority_encoder_4to2 #(.REG_OUT(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n),
        .I0(in[0]), .I1(in[1]), .I2(in[2]), .I3(in[3]),
        .Y1(r_y1), .Y0(r_y0), .valid(r_valid)
    );

    function automatic logic [2:0] model(input logic [3:0] v);
        logic [2:0] r;
        r = 3'b000;
        for (int k = 0; k < 4; k++)
            if (v[k]) r = {1'b1, 2'(k)};
        return r;
    endfunction

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {valid,Y1,Y0}=%b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply v just after an edge: the edge just passed must show the previous
    // expectation, and the registered output must hold until the next edge.
    task automatic drive(input logic [3:0] v);
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            last_reg = sb.pop_front();
            check("reg", {r_valid, r_y1, r_y0}, last_reg);
        end
        in = v;
        sb.push_back(model(v));
        #1;
        check("comb", {c_valid, c_y1, c_y0}, model(v));
        check("reg_hold", {r_valid, r_y1, r_y0}, last_reg);
    endtask

    initial begin
        logic [3:0] dir[12];
        dir = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b1110, 4'b1111};

        #2;
        check("reset_reg", {r_valid, r_y1, r_y0}, 3'b000);
        check("reset_comb", {c_valid, c_y1, c_y0}, 3'b000);
        in = 4'b1111;
        #1;
        check("reset_comb_live", {c_valid, c_y1, c_y0}, 3'b111);
        @(posedge clk);
        #1;
        check("reset_reg_hold", {r_valid, r_y1, r_y0}, 3'b000);
        in = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (dir[i]) drive(dir[i]);
        for (int i = 0; i < 16; i++) drive(4'(i));
        for (int i = 0; i < 20; i++) drive(4'($urandom_range(0, 15)));

        drive(4'b0000);
        drive(4'b0100);
        drive(4'b1000);
        drive(4'b1000);
        check("pre_rst", {r_valid, r_y1, r_y0}, 3'b111);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async", {r_valid, r_y1, r_y0}, 3'b000);
        check("rst_comb", {c_valid, c_y1, c_y0}, 3'b111);
        sb.delete();
        @(posedge clk);
        #1;
        check("rst_held", {r_valid, r_y1, r_y0}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release", {r_valid, r_y1, r_y0}, 3'b000);
        @(posedge clk);
        #1;
        check("rst_first_edge", {r_valid, r_y1, r_y0}, 3'b111);
        last_reg = 3'b111;

        drive(4'b0011);
        drive(4'b0000);
        drive(4'b0000);
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            check("reg_flush", {r_valid, r_y1, r_y0}, sb.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
